// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, redirect and IF/ID handshake signals.
interface fetch_stage_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; the head entry is readable in the
// cycle after it is pushed.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues in-order word fetches, buffers the
// returned words with their PCs and hands them to decode; redirects flush.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   tag_mem_q [DEPTH];
    logic [PW-1:0] tag_wr_q, tag_rd_q;

    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty, fifo_full;
    logic          issue, rsp_keep, pop;

    assign bus.imem_req_valid = !rst && !bus.redirect_valid
                                && ((outstanding_q + fifo_cnt) < CW'(DEPTH));
    assign bus.imem_req_addr  = pc_q;

    assign issue    = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep = bus.imem_rsp_valid && !bus.redirect_valid && (discard_q == '0);
    assign pop      = bus.id_valid && bus.id_ready && !bus.redirect_valid;

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(bus.imem_rsp_valid);
        discard_d     = discard_q;
        if (bus.redirect_valid) begin
            pc_d      = bus.redirect_pc & ~32'h3;
            discard_d = outstanding_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (issue) pc_d = pc_q + 32'd4;
            if (bus.imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    // The tag queue only holds PCs of fetches that will be kept, so a
    // discarded response leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (bus.redirect_valid) begin
                tag_wr_q <= '0;
                tag_rd_q <= '0;
            end else begin
                if (issue)    tag_wr_q <= tag_wr_q + PW'(1);
                if (rsp_keep) tag_rd_q <= tag_rd_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) tag_mem_q[tag_wr_q] <= pc_q;
    end

    assign push_entry.pc    = tag_mem_q[tag_rd_q];
    assign push_entry.instr = bus.imem_rsp_data;

    fetch_fifo #(.DEPTH(DEPTH)) u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.redirect_valid),
        .push_i      (rsp_keep),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_cnt),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign bus.id_valid       = !fifo_empty;
    assign bus.id_instruction = fifo_empty ? 32'h0 : head.instr;
    assign bus.id_pc          = fifo_empty ? 32'h0 : head.pc;

    // Credit accounting keeps a slot free for every outstanding fetch.
    assert property (@(posedge clk) disable iff (rst) !(rsp_keep && fifo_full));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based model of the
// memory, the redirect rules and the expected decode stream.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_err = 0;
    int          n_chk = 0;
    int          n_id  = 0;
    int          cyc   = 0;
    int          rdy_pct = 100, idr_pct = 100, lat_lo = 1, lat_hi = 1;
    logic [31:0] exp_pc = 32'h0;
    pend_t       pend[$];
    exp_t        expq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%08h want=%08h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return INSTR_NOP;
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model with whatever happened at the rising edge.
    task automatic cycle(input bit redir, input logic [31:0] tgt);
        pend_t d;
        bit    delivered, acc, pop_ok;
        int    inflight;
        exp_t  e;
        @(negedge clk);
        bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
        bus.id_ready       = ($urandom_range(99) < idr_pct);
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        delivered = 0;
        if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            d = pend.pop_front();
            delivered = 1;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(d.addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom();
        end
        #1;
        inflight = pend.size() + int'(delivered);
        chk("req_valid", 32'(bus.imem_req_valid), 32'(!redir && (inflight + expq.size() < DEPTH)));
        chk("req_addr", bus.imem_req_addr, exp_pc);
        chk("id_valid", 32'(bus.id_valid), 32'(expq.size() > 0));
        if (bus.id_valid && expq.size() > 0) begin
            chk("id_pc", bus.id_pc, expq[0].pc);
            chk("id_instr", bus.id_instruction, expq[0].instr);
        end
        acc    = bus.imem_req_valid && bus.imem_req_ready;
        pop_ok = bus.id_valid && bus.id_ready && !redir;
        @(posedge clk);
        cyc++;
        if (redir) begin
            expq.delete();
            foreach (pend[i]) pend[i].live = 0;
            exp_pc = tgt & ~32'h3;
        end else begin
            if (pop_ok && expq.size() > 0) begin
                $display("id  pc=%08h instr=%08h", expq[0].pc, expq[0].instr);
                void'(expq.pop_front());
                n_id++;
            end
            if (delivered && d.live) begin
                e.pc = d.addr;
                e.instr = mem_word(d.addr);
                expq.push_back(e);
            end
            if (acc) begin
                d.addr = exp_pc;
                d.due  = cyc + $urandom_range(lat_hi, lat_lo);
                d.live = 1;
                pend.push_back(d);
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    initial begin
        bit last_redir;
        bit do_redir;
        int budget;

        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_id_valid", 32'(bus.id_valid), 32'h0);
        chk("rst_id_instr", bus.id_instruction, 32'h0);
        chk("rst_id_pc", bus.id_pc, 32'h0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        rst = 1'b0;

        // Streaming with 1-cycle memory.
        repeat (20) cycle(1'b0, 32'h0);

        // Decode stalls, then resumes.
        idr_pct = 0;
        repeat (5) cycle(1'b0, 32'h0);
        idr_pct = 100;
        repeat (6) cycle(1'b0, 32'h0);

        // Redirect with slow memory so fetches are in flight.
        lat_lo = 3; lat_hi = 3;
        repeat (6) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h100);
        #1;
        chk("redir100_addr", bus.imem_req_addr, 32'h100);
        chk("redir100_idv", 32'(bus.id_valid), 32'h0);
        repeat (12) cycle(1'b0, 32'h0);

        // Unaligned redirect during steady pop/response traffic.
        lat_lo = 1; lat_hi = 1;
        repeat (8) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h203);
        #1;
        chk("redir203_addr", bus.imem_req_addr, 32'h200);
        chk("redir203_idv", 32'(bus.id_valid), 32'h0);
        repeat (8) cycle(1'b0, 32'h0);

        // PC wrap at the top of the address space.
        cycle(1'b1, 32'hFFFF_FFF8);
        repeat (10) cycle(1'b0, 32'h0);

        // Random ready, latency, decode back-pressure and redirects.
        rdy_pct = 60; idr_pct = 70; lat_lo = 1; lat_hi = 3;
        last_redir = 0;
        repeat (400) begin
            do_redir = !last_redir && ($urandom_range(39) == 0);
            cycle(do_redir, $urandom());
            last_redir = do_redir;
        end

        // Drain everything still in flight or buffered.
        rdy_pct = 0; idr_pct = 100;
        budget = 0;
        while ((pend.size() > 0 || expq.size() > 0) && budget < 200) begin
            cycle(1'b0, 32'h0);
            budget++;
        end
        chk("drain_done", 32'(pend.size() + expq.size()), 32'h0);
        chk("id_seen", 32'(n_id > 50), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
